// File: rtl/ddr_port_pkg.sv
// Shared definitions for the DDR port clients and the fixed-priority arbiter.
// Contents:
//   state_e        - requester FSM state encoding (IDLE, REQ, CMD, DATA)
//   PORT_*         - arbiter request/grant bit index of each client port
//   DEF_BURST_LEN  - default number of beats per write burst
package ddr_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CMD  = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam int PORT_CAMERA = 0;
    localparam int PORT_HDMI   = 1;
    localparam int PORT_AUDIO  = 2;
    localparam int PORT_SPARE  = 3;

    localparam int DEF_BURST_LEN = 64;

endpackage

// File: rtl/ddr_addr_gen.sv
// Burst start-address generator for one DDR write port.
// Holds the current burst address, advances it by one burst when a burst
// completes, wraps it back to BASE_ADDR at the end of the port's region
// (pulsing o_frame_wrap), and handles frame rewinds, which are deferred
// while a burst is in flight.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   i_idle          - requester is in IDLE (a deferred rewind may be applied)
//   i_can_rewind    - requester is in IDLE or REQ (rewind applies at once)
//   i_frame_start   - one-cycle frame start pulse
//   i_burst_done    - last beat of the current burst accepted
//   o_addr          - burst start beat address
//   o_frame_wrap    - one-cycle pulse when the address wraps to BASE_ADDR
module ddr_addr_gen
    import ddr_port_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_BEATS = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_idle,
    input  logic              i_can_rewind,
    input  logic              i_frame_start,
    input  logic              i_burst_done,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_frame_wrap
);

    // One extra bit so the end-of-region compare cannot overflow.
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(BASE_ADDR + REGION_BEATS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] r_addr;
    logic              r_rewind_pend;
    logic              r_frame_wrap;
    logic [ADDR_W:0]   w_next;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_adv;

    // Next burst address after the current one, wrapped into the region.
    always_comb begin
        w_next = {1'b0, r_addr} + (ADDR_W+1)'(BURST_LEN);
        w_wrap = (w_next >= LIMIT);
        if (w_wrap) begin
            w_adv = BASE;
        end else begin
            w_adv = w_next[ADDR_W-1:0];
        end
    end

    // Address register, deferred-rewind flag and wrap pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= BASE;
            r_rewind_pend <= 1'b0;
            r_frame_wrap  <= 1'b0;
        end else begin
            r_frame_wrap <= 1'b0;
            if (i_burst_done) begin
                // A rewind requested during the burst (or on its last beat)
                // wins over the normal advance and suppresses frame_wrap.
                if (r_rewind_pend || i_frame_start) begin
                    r_addr        <= BASE;
                    r_rewind_pend <= 1'b0;
                end else begin
                    r_addr       <= w_adv;
                    r_frame_wrap <= w_wrap;
                end
            end else if (i_frame_start) begin
                if (i_can_rewind) begin
                    r_addr        <= BASE;
                    r_rewind_pend <= 1'b0;
                end else begin
                    r_rewind_pend <= 1'b1;
                end
            end else if (i_idle && r_rewind_pend) begin
                r_addr        <= BASE;
                r_rewind_pend <= 1'b0;
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_frame_wrap = r_frame_wrap;

endmodule

// File: rtl/ddr_wr_requester.sv
// Client-side DDR write requester. Watches a show-ahead (FWFT) client FIFO,
// requests the DDR port from the arbiter once a full burst is buffered,
// issues one write command on grant and streams exactly BURST_LEN beats.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   enable                     - port enable, sampled in IDLE only
//   frame_start                - rewind burst address to BASE_ADDR
//   fifo_rd_level/data/en      - client FWFT FIFO level, head word, pop
//   request / grant            - arbiter handshake for this port
//   cmd_valid/ready/addr/len   - write command to the DDR controller
//   wr_valid/ready/data/last   - write data beats to the DDR controller
//   frame_wrap                 - pulse when the address wraps to BASE_ADDR
module ddr_wr_requester
    import ddr_port_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int LVL_W        = 10,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_BEATS = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              request,
    input  logic              grant,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              frame_wrap
);

    localparam int CNT_W = $clog2(BURST_LEN);

    state_e             r_state;
    logic               r_request;
    logic               r_cmd_valid;
    logic               r_wr_valid;
    logic               r_wr_last;
    logic [CNT_W-1:0]   r_beat;

    logic               w_accept;
    logic               w_last_accept;
    logic               w_level_ok;

    assign w_accept      = r_wr_valid & wr_ready;
    assign w_last_accept = w_accept & (r_beat == CNT_W'(BURST_LEN - 1));
    assign w_level_ok    = ({1'b0, fifo_rd_level} >= (LVL_W+1)'(BURST_LEN));

    // Request/command/data FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_request   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_last   <= 1'b0;
            r_beat      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_level_ok) begin
                        r_state   <= ST_REQ;
                        r_request <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (grant) begin
                        r_state     <= ST_CMD;
                        r_cmd_valid <= 1'b1;
                    end
                end
                ST_CMD: begin
                    // grant no longer matters: the downstream mux holds on request.
                    if (cmd_ready) begin
                        r_state     <= ST_DATA;
                        r_cmd_valid <= 1'b0;
                        r_wr_valid  <= 1'b1;
                        r_wr_last   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_last_accept) begin
                        // Dropping request here guarantees one idle cycle
                        // before the next burst can re-request.
                        r_state    <= ST_IDLE;
                        r_request  <= 1'b0;
                        r_wr_valid <= 1'b0;
                        r_wr_last  <= 1'b0;
                        r_beat     <= '0;
                    end else if (w_accept) begin
                        r_beat    <= r_beat + CNT_W'(1);
                        r_wr_last <= (r_beat == CNT_W'(BURST_LEN - 2));
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_request   <= 1'b0;
                    r_cmd_valid <= 1'b0;
                    r_wr_valid  <= 1'b0;
                    r_wr_last   <= 1'b0;
                    r_beat      <= '0;
                end
            endcase
        end
    end

    ddr_addr_gen #(
        .ADDR_W       (ADDR_W),
        .BURST_LEN    (BURST_LEN),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_BEATS (REGION_BEATS)
    ) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_idle        (r_state == ST_IDLE),
        .i_can_rewind  ((r_state == ST_IDLE) || (r_state == ST_REQ)),
        .i_frame_start (frame_start),
        .i_burst_done  (w_last_accept),
        .o_addr        (cmd_addr),
        .o_frame_wrap  (frame_wrap)
    );

    assign request    = r_request;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_len    = 8'(BURST_LEN - 1);
    assign wr_valid   = r_wr_valid;
    assign wr_last    = r_wr_last;
    // FWFT head is forwarded directly; a stalled beat keeps its data
    // because nothing is popped.
    assign wr_data    = fifo_rd_data;
    assign fifo_rd_en = w_accept;

endmodule

// File: tb/tb_ddr_wr_requester.sv
module tb_ddr_wr_requester;

    localparam int ADDR_W    = 28;
    localparam int DATA_W    = 128;
    localparam int BURST_LEN = 64;
    localparam int LVL_W     = 10;
    localparam int REGION    = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              frame_start = 1'b0;
    logic [LVL_W-1:0]  fifo_rd_level = 10'd0;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              request;
    logic              grant = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              frame_wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int head    = 0;
    int pops    = 0;
    int exp_word = 0;

    logic [DATA_W-1:0] q_data[$];
    logic [ADDR_W-1:0] q_addr[$];

    always #5 clk = ~clk;

    ddr_wr_requester #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BURST_LEN    (BURST_LEN),
        .LVL_W        (LVL_W),
        .BASE_ADDR    (0),
        .REGION_BEATS (REGION)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_start   (frame_start),
        .fifo_rd_level (fifo_rd_level),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .request       (request),
        .grant         (grant),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .frame_wrap    (frame_wrap)
    );

    function automatic logic [DATA_W-1:0] word_of(input int i);
        return {4{32'hC0DE0000 ^ 32'(i)}};
    endfunction

    // FWFT client FIFO model: head word advances on every pop.
    assign fifo_rd_data = word_of(head);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            head <= head + 1;
            pops <= pops + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full burst: wait request, grant, command, data; checks everything on the way.
    task automatic run_burst(input string nm, input logic [ADDR_W-1:0] exp_addr,
                             input int grant_wait, input bit toggle,
                             input int fs_beat, input int rst_beat, input bit exp_wrap);
        int waitc;
        int beat;
        int cyc;
        int pops0;
        int base;
        bit fs_done;
        waitc = 0;
        while (!request && waitc < 10) begin
            tick();
            waitc++;
        end
        check_eq({nm, ":request"}, request, 1'b1);
        base = exp_word;
        q_addr.push_back(exp_addr);
        for (int i = 0; i < BURST_LEN; i++) q_data.push_back(word_of(base + i));
        exp_word = base + BURST_LEN;
        pops0 = pops;
        for (int i = 0; i < grant_wait; i++) begin
            tick();
            check_eq({nm, ":req_hold"}, request, 1'b1);
            check_eq({nm, ":no_cmd"}, cmd_valid, 1'b0);
        end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check_eq({nm, ":cmd_valid"}, cmd_valid, 1'b1);
        check_eq({nm, ":cmd_addr"}, cmd_addr, q_addr.pop_front());
        check_eq({nm, ":cmd_len"}, cmd_len, 8'd63);
        tick();
        check_eq({nm, ":cmd_stall_valid"}, cmd_valid, 1'b1);
        check_eq({nm, ":cmd_stall_addr"}, cmd_addr, exp_addr);
        check_eq({nm, ":no_data_in_cmd"}, wr_valid, 1'b0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_eq({nm, ":wr_valid_first"}, wr_valid, 1'b1);
        check_eq({nm, ":cmd_dropped"}, cmd_valid, 1'b0);
        beat = 0;
        cyc = 0;
        fs_done = 1'b0;
        while (beat < BURST_LEN && cyc < 400) begin
            if (beat == rst_beat) begin
                wr_ready = 1'b0;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                frame_start = 1'b0;
                check_eq({nm, ":rst_request"}, request, 1'b0);
                check_eq({nm, ":rst_cmd_valid"}, cmd_valid, 1'b0);
                check_eq({nm, ":rst_wr_valid"}, wr_valid, 1'b0);
                check_eq({nm, ":rst_wr_last"}, wr_last, 1'b0);
                check_eq({nm, ":rst_rd_en"}, fifo_rd_en, 1'b0);
                check_eq({nm, ":rst_wrap"}, frame_wrap, 1'b0);
                check_eq({nm, ":rst_addr"}, cmd_addr, 28'd0);
                q_data.delete();
                exp_word = base + beat;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check_eq({nm, ":post_rst_rd_en"}, fifo_rd_en, 1'b0);
                    check_eq({nm, ":post_rst_wr_valid"}, wr_valid, 1'b0);
                end
                check_eq({nm, ":rst_pops"}, 32'(pops - pops0), 32'(rst_beat));
                return;
            end
            wr_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            frame_start = (beat == fs_beat) && !fs_done;
            if (frame_start) fs_done = 1'b1;
            #1;
            check_eq({nm, ":wr_valid"}, wr_valid, 1'b1);
            check_eq({nm, ":wr_data"}, wr_data, q_data[0]);
            check_eq({nm, ":wr_last"}, wr_last, (beat == BURST_LEN - 1));
            check_eq({nm, ":rd_en"}, fifo_rd_en, wr_ready);
            if (wr_ready) begin
                void'(q_data.pop_front());
                beat++;
            end
            tick();
            frame_start = 1'b0;
            cyc++;
        end
        wr_ready = 1'b0;
        frame_start = 1'b0;
        check_eq({nm, ":data_timeout"}, 32'(beat), 32'(BURST_LEN));
        check_eq({nm, ":req_low_after"}, request, 1'b0);
        check_eq({nm, ":wr_valid_low"}, wr_valid, 1'b0);
        check_eq({nm, ":frame_wrap"}, frame_wrap, exp_wrap);
        check_eq({nm, ":pop_count"}, 32'(pops - pops0), 32'(BURST_LEN));
        tick();
        check_eq({nm, ":wrap_one_cycle"}, frame_wrap, 1'b0);
    endtask

    initial begin
        fifo_rd_level = 10'd63;
        tick();
        tick();
        check_eq("reset:request", request, 1'b0);
        check_eq("reset:cmd_valid", cmd_valid, 1'b0);
        check_eq("reset:wr_valid", wr_valid, 1'b0);
        check_eq("reset:wr_last", wr_last, 1'b0);
        check_eq("reset:rd_en", fifo_rd_en, 1'b0);
        check_eq("reset:frame_wrap", frame_wrap, 1'b0);
        check_eq("reset:cmd_addr", cmd_addr, 28'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("level63:no_request", request, 1'b0);
        end
        fifo_rd_level = 10'd64;
        #1;
        check_eq("level64:not_yet", request, 1'b0);
        tick();
        check_eq("level64:request", request, 1'b1);

        run_burst("b0_toggle", 28'd0,  20, 1'b1, -1, -1, 1'b0);
        run_burst("b1_wrap",   28'd64,  0, 1'b0, -1, -1, 1'b1);
        run_burst("b2_after",  28'd0,   0, 1'b0, -1, -1, 1'b0);
        run_burst("b3_fs_mid", 28'd64,  0, 1'b1, 10, -1, 1'b0);
        run_burst("b4_fs_last",28'd0,   0, 1'b0, 63, -1, 1'b0);
        run_burst("b5_rewound",28'd0,   0, 1'b0, -1, -1, 1'b0);
        run_burst("b6_reset",  28'd64,  0, 1'b0, -1, 10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
